ysyx_22050710_rf_warb: RTL and testbench

Write-port arbiter for the single GPR register-file write port. It sits between the write-back stage and the register file, and shares the port between two requesters. The in-order pipeline write-back (WS) has priority by default. The long-latency unit result (LU, e.g. multi-cycle MUL/DIV) is the second requester. Anti-starvation scheduling guarantees LU forward progress. The grant is returned as `o_ws_ready` (feeds `ws_ready_go`) and `o_lu_ready`.

---
 rtl/ysyx_22050710_rf_warb_if.sv | 34 +++
 rtl/ysyx_22050710_rf_warb.sv | 122 ++++++++++++
 tb/tb_ysyx_22050710_rf_warb.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050710_rf_warb_if.sv
// GPR write-port arbiter bus: WS and LU requests in, grants and registered RF write out.
// master = requester/pipeline side, slave = arbiter side.
interface ysyx_22050710_rf_warb_if #(
   parameter int unsigned GPR_ADDR_WD = 5,
   parameter int unsigned GPR_WD      = 64
);
   logic                   i_ws_valid;
   logic                   i_ws_wen;
   logic [GPR_ADDR_WD-1:0] i_ws_waddr;
   logic [GPR_WD-1:0]      i_ws_wdata;
   logic                   o_ws_ready;
   logic                   i_lu_valid;
   logic [GPR_ADDR_WD-1:0] i_lu_waddr;
   logic [GPR_WD-1:0]      i_lu_wdata;
   logic                   o_lu_ready;
   logic                   o_rf_wen;
   logic [GPR_ADDR_WD-1:0] o_rf_waddr;
   logic [GPR_WD-1:0]      o_rf_wdata;
   logic                   o_rf_src_lu;

   modport master (
      output i_ws_valid, i_ws_wen, i_ws_waddr, i_ws_wdata,
      output i_lu_valid, i_lu_waddr, i_lu_wdata,
      input  o_ws_ready, o_lu_ready,
      input  o_rf_wen, o_rf_waddr, o_rf_wdata, o_rf_src_lu
   );

   modport slave (
      input  i_ws_valid, i_ws_wen, i_ws_waddr, i_ws_wdata,
      input  i_lu_valid, i_lu_waddr, i_lu_wdata,
      output o_ws_ready, o_lu_ready,
      output o_rf_wen, o_rf_waddr, o_rf_wdata, o_rf_src_lu
   );
endinterface

// File: rtl/ysyx_22050710_rf_warb.sv
// Single GPR write-port arbiter: WS has priority, LU gets anti-starvation boost.
// Define YSYX_22050710_RF_WARB_STARVE_EN to build the starvation counter / LU_PRIO state.
module ysyx_22050710_rf_warb #(
   parameter int unsigned GPR_ADDR_WD = 5,
   parameter int unsigned GPR_WD      = 64,
   parameter int unsigned STARVE_MAX  = 8,
   parameter int unsigned CNT_WD      = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   ysyx_22050710_rf_warb_if.slave bus
);

   // Reject configurations where the counter cannot reach STARVE_MAX-1.
   if ((STARVE_MAX < 1) || ((64'(1) << CNT_WD) <= 64'(STARVE_MAX))) begin : g_cfg_err
      $error("rf_warb: need STARVE_MAX >= 1 and 2**CNT_WD > STARVE_MAX");
   end

   logic w_ws_req;
   logic w_lu_wr;
   logic w_ws_grant;
   logic w_lu_grant;

   logic                   r_rf_wen;
   logic [GPR_ADDR_WD-1:0] r_rf_waddr;
   logic [GPR_WD-1:0]      r_rf_wdata;
   logic                   r_rf_src_lu;

   assign w_ws_req = bus.i_ws_valid & bus.i_ws_wen & (bus.i_ws_waddr != '0);
   assign w_lu_wr  = bus.i_lu_valid & (bus.i_lu_waddr != '0);

`ifdef YSYX_22050710_RF_WARB_STARVE_EN
   typedef enum logic [0:0] {
      WS_PRIO = 1'b0,
      LU_PRIO = 1'b1
   } state_t;

   localparam logic [CNT_WD-1:0] CNT_SAT = CNT_WD'(STARVE_MAX - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_WD-1:0] r_starve_cnt;
   logic [CNT_WD-1:0] w_starve_cnt_nxt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= WS_PRIO;
         r_starve_cnt <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_starve_cnt_nxt;
      end
   end

   // Counter clears by default; it only advances while LU loses in WS_PRIO.
   always_comb begin
      w_state_nxt      = r_state;
      w_starve_cnt_nxt = '0;
      w_ws_grant       = 1'b0;
      w_lu_grant       = 1'b0;
      if (i_rst_n) begin
         case (r_state)
            WS_PRIO: begin
               if (w_ws_req) begin
                  w_ws_grant = 1'b1;
                  if (bus.i_lu_valid) begin
                     w_starve_cnt_nxt = (r_starve_cnt == CNT_SAT) ? CNT_SAT
                                                                  : r_starve_cnt + CNT_WD'(1);
                     if (r_starve_cnt == CNT_SAT) begin
                        w_state_nxt = LU_PRIO;
                     end
                  end
               end else begin
                  w_lu_grant = bus.i_lu_valid;
               end
            end
            LU_PRIO: begin
               if (bus.i_lu_valid) begin
                  w_lu_grant = 1'b1;
               end else begin
                  w_ws_grant = w_ws_req;
               end
               w_state_nxt = WS_PRIO;
            end
         endcase
      end
   end
`else
   assign w_ws_grant = i_rst_n & w_ws_req;
   assign w_lu_grant = i_rst_n & ~w_ws_req & bus.i_lu_valid;
`endif

   // WS without a port need always retires; a requesting WS only on grant.
   assign bus.o_ws_ready = i_rst_n & (w_ws_grant | ~w_ws_req);
   assign bus.o_lu_ready = w_lu_grant;

   // Winner captured into the write registers; LU writes to x0 are acked but dropped.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rf_wen    <= 1'b0;
         r_rf_waddr  <= '0;
         r_rf_wdata  <= '0;
         r_rf_src_lu <= 1'b0;
      end else begin
         r_rf_wen    <= w_ws_grant | (w_lu_grant & w_lu_wr);
         r_rf_src_lu <= ~w_ws_grant & w_lu_grant & w_lu_wr;
         if (w_ws_grant) begin
            r_rf_waddr <= bus.i_ws_waddr;
            r_rf_wdata <= bus.i_ws_wdata;
         end else if (w_lu_grant & w_lu_wr) begin
            r_rf_waddr <= bus.i_lu_waddr;
            r_rf_wdata <= bus.i_lu_wdata;
         end
      end
   end

   assign bus.o_rf_wen    = r_rf_wen;
   assign bus.o_rf_waddr  = r_rf_waddr;
   assign bus.o_rf_wdata  = r_rf_wdata;
   assign bus.o_rf_src_lu = r_rf_src_lu;

endmodule

// File: tb/tb_ysyx_22050710_rf_warb.sv
// Directed bench for ysyx_22050710_rf_warb: single-cycle vector table plus
// reset, starvation and mid-starvation-reset sequences.
module tb_ysyx_22050710_rf_warb;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 64;

`ifdef YSYX_22050710_RF_WARB_STARVE_EN
   localparam int GNT_AT = 8;
`else
   localparam int GNT_AT = -1;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   ws_idx  = 0;

   always #5 clk = ~clk;

   ysyx_22050710_rf_warb_if #(.GPR_ADDR_WD(AW), .GPR_WD(DW)) bus ();

   ysyx_22050710_rf_warb #(
      .GPR_ADDR_WD(AW), .GPR_WD(DW), .STARVE_MAX(8), .CNT_WD(4)
   ) u_dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
   );

   typedef struct {
      logic          ws_v;
      logic          ws_wen;
      logic [AW-1:0] ws_a;
      logic [DW-1:0] ws_d;
      logic          lu_v;
      logic [AW-1:0] lu_a;
      logic [DW-1:0] lu_d;
      logic          e_wsr;
      logic          e_lur;
      logic          e_wen;
      logic [AW-1:0] e_a;
      logic [DW-1:0] e_d;
      logic          e_src;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_rf(input string nm, input logic e_wen, input logic [AW-1:0] e_a,
                         input logic [DW-1:0] e_d, input logic e_src);
      chk({nm, ".wen"}, 64'(bus.o_rf_wen), 64'(e_wen));
      if (e_wen) begin
         chk({nm, ".waddr"}, 64'(bus.o_rf_waddr), 64'(e_a));
         chk({nm, ".wdata"}, bus.o_rf_wdata, e_d);
         chk({nm, ".src_lu"}, 64'(bus.o_rf_src_lu), 64'(e_src));
      end
   endtask

   task automatic set_in(input logic ws_v, input logic ws_wen, input logic [AW-1:0] ws_a,
                         input logic [DW-1:0] ws_d, input logic lu_v,
                         input logic [AW-1:0] lu_a, input logic [DW-1:0] lu_d);
      bus.i_ws_valid = ws_v;
      bus.i_ws_wen   = ws_wen;
      bus.i_ws_waddr = ws_a;
      bus.i_ws_wdata = ws_d;
      bus.i_lu_valid = lu_v;
      bus.i_lu_waddr = lu_a;
      bus.i_lu_wdata = lu_d;
   endtask

   function automatic logic [AW-1:0] ws_addr(input int i);
      return AW'(1 + (i % 30));
   endfunction

   function automatic logic [DW-1:0] ws_dat(input int i);
      return 64'h100 + 64'(i);
   endfunction

   // WS requests every cycle with a fresh instruction after each retire; LU holds rd12.
   task automatic contend(input int ncyc, input int gnt_at, input bit drop);
      bit lu_pend;
      bit g;
      lu_pend = 1'b1;
      for (int k = 0; k < ncyc; k++) begin
         set_in(1'b1, 1'b1, ws_addr(ws_idx), ws_dat(ws_idx), lu_pend, AW'(12), 64'hBEEF);
         g = lu_pend && (k == gnt_at);
         @(negedge clk);
         chk($sformatf("cont%0d.ws_ready", k), 64'(bus.o_ws_ready), 64'(!g));
         chk($sformatf("cont%0d.lu_ready", k), 64'(bus.o_lu_ready), 64'(g));
         @(posedge clk); #1;
         if (g) begin
            chk_rf($sformatf("cont%0d.lu", k), 1'b1, AW'(12), 64'hBEEF, 1'b1);
            lu_pend = 1'b0;
         end else begin
            chk_rf($sformatf("cont%0d.ws", k), 1'b1, ws_addr(ws_idx), ws_dat(ws_idx), 1'b0);
            ws_idx++;
         end
      end
      if (drop) begin
         set_in(1'b0, 1'b0, '0, '0, lu_pend, AW'(12), 64'hBEEF);
         @(negedge clk);
         chk("drop.lu_ready", 64'(bus.o_lu_ready), 64'(lu_pend));
         @(posedge clk); #1;
         chk_rf("drop", lu_pend, AW'(12), 64'hBEEF, 1'b1);
      end
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b1, 5'd5,  64'h1234, 1'b0, 5'd0,  64'h0,
                  1'b1, 1'b0, 1'b1, 5'd5,  64'h1234, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 5'd3,  64'h9999, 1'b1, 5'd7,  64'hAA,
                  1'b1, 1'b1, 1'b1, 5'd7,  64'hAA, 1'b1};
      vecs[2] = '{1'b1, 1'b0, 5'd0,  64'h0,    1'b1, 5'd0,  64'h77,
                  1'b1, 1'b1, 1'b0, 5'd0,  64'h0, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 5'd3,  64'h3333, 1'b1, 5'd9,  64'h9090,
                  1'b1, 1'b0, 1'b1, 5'd3,  64'h3333, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 5'd0,  64'hDEAD, 1'b0, 5'd0,  64'h0,
                  1'b1, 1'b0, 1'b0, 5'd0,  64'h0, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 5'd0,  64'h0,    1'b0, 5'd4,  64'h44,
                  1'b1, 1'b0, 1'b0, 5'd0,  64'h0, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 5'd4,  64'hC0DE, 1'b1, 5'd4,  64'hF00D,
                  1'b1, 1'b0, 1'b1, 5'd4,  64'hC0DE, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 5'd2,  64'h0,    1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF,
                  1'b1, 1'b1, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};

      // Reset with both requesters valid.
      set_in(1'b1, 1'b1, 5'd6, 64'h55, 1'b1, 5'd7, 64'h66);
      #3;
      chk("rst.ws_ready", 64'(bus.o_ws_ready), 64'd0);
      chk("rst.lu_ready", 64'(bus.o_lu_ready), 64'd0);
      chk("rst.wen", 64'(bus.o_rf_wen), 64'd0);
      chk("rst.waddr", 64'(bus.o_rf_waddr), 64'd0);
      chk("rst.wdata", bus.o_rf_wdata, 64'd0);
      chk("rst.src_lu", 64'(bus.o_rf_src_lu), 64'd0);
      @(posedge clk); #1;
      chk("rst_edge.wen", 64'(bus.o_rf_wen), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel.ws_ready", 64'(bus.o_ws_ready), 64'd1);
      chk("rel.lu_ready", 64'(bus.o_lu_ready), 64'd0);
      @(posedge clk); #1;
      chk_rf("rel", 1'b1, 5'd6, 64'h55, 1'b0);
      set_in(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
      @(posedge clk); #1;

      // Single-cycle vectors, each followed by an idle cycle.
      for (int i = 0; i < 8; i++) begin
         set_in(vecs[i].ws_v, vecs[i].ws_wen, vecs[i].ws_a, vecs[i].ws_d,
                vecs[i].lu_v, vecs[i].lu_a, vecs[i].lu_d);
         @(negedge clk);
         chk($sformatf("vec%0d.ws_ready", i), 64'(bus.o_ws_ready), 64'(vecs[i].e_wsr));
         chk($sformatf("vec%0d.lu_ready", i), 64'(bus.o_lu_ready), 64'(vecs[i].e_lur));
         @(posedge clk); #1;
         chk_rf($sformatf("vec%0d", i), vecs[i].e_wen, vecs[i].e_a, vecs[i].e_d, vecs[i].e_src);
         set_in(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
         @(posedge clk); #1;
         chk($sformatf("idle%0d.wen", i), 64'(bus.o_rf_wen), 64'd0);
      end

      // Continuous contention: LU forced through after 8 losses (or only when WS drops).
      contend(12, GNT_AT, 1'b1);

      // Reset in the middle of starvation: the count restarts, the request survives.
      contend(4, -1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mrst.ws_ready", 64'(bus.o_ws_ready), 64'd0);
      chk("mrst.lu_ready", 64'(bus.o_lu_ready), 64'd0);
      chk("mrst.wen", 64'(bus.o_rf_wen), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      contend(12, GNT_AT, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
